csr_cpuif_timeout_bridge: RTL and testbench

- Single-outstanding request buffer between the AXI-to-CSR adapter's CSR access (cpuif) port and the I3CCSR register block.
- Registers each CSR request and forwards it downstream, honouring downstream stalls.
- Returns the ack, data and error upstream as a one-cycle pulse.
- Replaces any access the register block never acknowledges with an error ack after a programmable cycle budget, so the AXI channel cannot hang.

---
 rtl/csr_cpuif_timeout_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_csr_cpuif_timeout_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_cpuif_timeout_bridge.sv
// Single-outstanding CSR cpuif request buffer that converts unacknowledged accesses into error acks.
// Optional timeout status outputs are built when CSR_CPUIF_TIMEOUT_STATUS_EN is defined.
module csr_cpuif_timeout_bridge #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256,
  parameter logic [31:0] TimeoutRdData = 32'hDEAD_C0DE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 u_req_i,
  input  logic                 u_req_is_wr_i,
  input  logic [AddrWidth-1:0] u_addr_i,
  input  logic [DataWidth-1:0] u_wr_data_i,
  input  logic [DataWidth-1:0] u_wr_biten_i,
  output logic                 u_req_stall_wr_o,
  output logic                 u_req_stall_rd_o,
  output logic                 u_rd_ack_o,
  output logic                 u_rd_err_o,
  output logic [DataWidth-1:0] u_rd_data_o,
  output logic                 u_wr_ack_o,
  output logic                 u_wr_err_o,
  output logic                 d_req_o,
  output logic                 d_req_is_wr_o,
  output logic [AddrWidth-1:0] d_addr_o,
  output logic [DataWidth-1:0] d_wr_data_o,
  output logic [DataWidth-1:0] d_wr_biten_o,
  input  logic                 d_req_stall_wr_i,
  input  logic                 d_req_stall_rd_i,
  input  logic                 d_rd_ack_i,
  input  logic                 d_rd_err_i,
  input  logic [DataWidth-1:0] d_rd_data_i,
  input  logic                 d_wr_ack_i,
`ifdef CSR_CPUIF_TIMEOUT_STATUS_EN
  output logic [7:0]           timeout_count_o,
  output logic [AddrWidth-1:0] timeout_addr_o,
  input  logic                 timeout_status_clr_i,
`endif
  input  logic                 d_wr_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [DataWidth-1:0] TimeoutData = DataWidth'(TimeoutRdData);

  state_e               state_r, state_nxt_s;
  logic                 is_wr_r;
  logic [AddrWidth-1:0] addr_r;
  logic [DataWidth-1:0] wr_data_r, biten_r, rd_data_r;
  logic                 err_r;
  logic                 d_stall_s, d_ack_s, d_err_s;
  logic                 expire_s, ack_take_s, timeout_s;

  assign d_stall_s = is_wr_r ? d_req_stall_wr_i : d_req_stall_rd_i;
  assign d_ack_s   = is_wr_r ? d_wr_ack_i : d_rd_ack_i;
  assign d_err_s   = is_wr_r ? d_wr_err_i : d_rd_err_i;

  // The budget runs through stalled issue cycles too, so a stuck stall also times out.
  if (TimeoutCycles > 0) begin : g_timeout
    localparam int unsigned          CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast  = CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
    logic [CntWidth-1:0] cnt_r;

    // Cycle budget counter, restarted when a new access is captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_r <= {CntWidth{1'b0}};
      end else if (state_r == ST_IDLE && u_req_i) begin
        cnt_r <= {CntWidth{1'b0}};
      end else if (state_r == ST_ISSUE || state_r == ST_WAIT) begin
        cnt_r <= cnt_r + CntOne;
      end
    end

    assign expire_s = (state_r == ST_ISSUE || state_r == ST_WAIT) && (cnt_r == CntLast);
  end else begin : g_no_timeout
    assign expire_s = 1'b0;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a matching ack always beats expiry in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    ack_take_s  = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (u_req_i) state_nxt_s = ST_ISSUE;
        else         state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (!d_stall_s && d_ack_s) begin
          state_nxt_s = ST_RESP;
          ack_take_s  = 1'b1;
        end else if (expire_s) begin
          state_nxt_s = ST_RESP;
          timeout_s   = 1'b1;
        end else if (!d_stall_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (d_ack_s) begin
          state_nxt_s = ST_RESP;
          ack_take_s  = 1'b1;
        end else if (expire_s) begin
          state_nxt_s = ST_RESP;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request capture and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      is_wr_r   <= 1'b0;
      addr_r    <= {AddrWidth{1'b0}};
      wr_data_r <= {DataWidth{1'b0}};
      biten_r   <= {DataWidth{1'b0}};
      err_r     <= 1'b0;
      rd_data_r <= {DataWidth{1'b0}};
    end else begin
      if (state_r == ST_IDLE && u_req_i) begin
        is_wr_r   <= u_req_is_wr_i;
        addr_r    <= u_addr_i;
        wr_data_r <= u_wr_data_i;
        biten_r   <= u_wr_biten_i;
      end
      if (ack_take_s) begin
        err_r     <= d_err_s;
        rd_data_r <= is_wr_r ? {DataWidth{1'b0}} : d_rd_data_i;
      end else if (timeout_s) begin
        err_r     <= 1'b1;
        rd_data_r <= is_wr_r ? {DataWidth{1'b0}} : TimeoutData;
      end
    end
  end

  // Outputs decode only the state and capture registers, never the upstream inputs.
  always_comb begin
    d_req_o          = (state_r == ST_ISSUE);
    d_req_is_wr_o    = is_wr_r;
    d_addr_o         = addr_r;
    d_wr_data_o      = wr_data_r;
    d_wr_biten_o     = biten_r;
    u_req_stall_wr_o = (state_r != ST_IDLE);
    u_req_stall_rd_o = (state_r != ST_IDLE);
    if (state_r == ST_RESP && !is_wr_r) begin
      u_rd_ack_o  = 1'b1;
      u_rd_err_o  = err_r;
      u_rd_data_o = rd_data_r;
    end else begin
      u_rd_ack_o  = 1'b0;
      u_rd_err_o  = 1'b0;
      u_rd_data_o = {DataWidth{1'b0}};
    end
    if (state_r == ST_RESP && is_wr_r) begin
      u_wr_ack_o = 1'b1;
      u_wr_err_o = err_r;
    end else begin
      u_wr_ack_o = 1'b0;
      u_wr_err_o = 1'b0;
    end
  end

`ifdef CSR_CPUIF_TIMEOUT_STATUS_EN
  logic [7:0]           tmo_count_r;
  logic [AddrWidth-1:0] tmo_addr_r;

  // Timeout status: clear beats the count, but a coincident timeout still records its address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_count_r <= 8'd0;
      tmo_addr_r  <= {AddrWidth{1'b0}};
    end else begin
      if (timeout_status_clr_i) begin
        tmo_count_r <= 8'd0;
      end else if (timeout_s && tmo_count_r != 8'hFF) begin
        tmo_count_r <= tmo_count_r + 8'd1;
      end
      if (timeout_s) begin
        tmo_addr_r <= addr_r;
      end else if (timeout_status_clr_i) begin
        tmo_addr_r <= {AddrWidth{1'b0}};
      end
    end
  end

  assign timeout_count_o = tmo_count_r;
  assign timeout_addr_o  = tmo_addr_r;
`endif

endmodule

// File: tb/tb_csr_cpuif_timeout_bridge.sv
// Scoreboard bench for csr_cpuif_timeout_bridge with an 8-cycle timeout budget.
module tb_csr_cpuif_timeout_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          u_req_i = 1'b0, u_req_is_wr_i = 1'b0;
  logic [AW-1:0] u_addr_i = '0;
  logic [DW-1:0] u_wr_data_i = '0, u_wr_biten_i = '0;
  logic          u_req_stall_wr_o, u_req_stall_rd_o;
  logic          u_rd_ack_o, u_rd_err_o, u_wr_ack_o, u_wr_err_o;
  logic [DW-1:0] u_rd_data_o;
  logic          d_req_o, d_req_is_wr_o;
  logic [AW-1:0] d_addr_o;
  logic [DW-1:0] d_wr_data_o, d_wr_biten_o;
  logic          d_req_stall_wr_i = 1'b0, d_req_stall_rd_i = 1'b0;
  logic          d_rd_ack_i = 1'b0, d_rd_err_i = 1'b0, d_wr_ack_i = 1'b0, d_wr_err_i = 1'b0;
  logic [DW-1:0] d_rd_data_i = '0;
`ifdef CSR_CPUIF_TIMEOUT_STATUS_EN
  logic [7:0]    timeout_count_o;
  logic [AW-1:0] timeout_addr_o;
  logic          timeout_status_clr_i = 1'b0;
`endif

  typedef struct {
    logic          is_wr;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  csr_cpuif_timeout_bridge #(
    .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(8), .TimeoutRdData(32'hDEAD_C0DE)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .u_req_i(u_req_i), .u_req_is_wr_i(u_req_is_wr_i), .u_addr_i(u_addr_i),
    .u_wr_data_i(u_wr_data_i), .u_wr_biten_i(u_wr_biten_i),
    .u_req_stall_wr_o(u_req_stall_wr_o), .u_req_stall_rd_o(u_req_stall_rd_o),
    .u_rd_ack_o(u_rd_ack_o), .u_rd_err_o(u_rd_err_o), .u_rd_data_o(u_rd_data_o),
    .u_wr_ack_o(u_wr_ack_o), .u_wr_err_o(u_wr_err_o),
    .d_req_o(d_req_o), .d_req_is_wr_o(d_req_is_wr_o), .d_addr_o(d_addr_o),
    .d_wr_data_o(d_wr_data_o), .d_wr_biten_o(d_wr_biten_o),
    .d_req_stall_wr_i(d_req_stall_wr_i), .d_req_stall_rd_i(d_req_stall_rd_i),
    .d_rd_ack_i(d_rd_ack_i), .d_rd_err_i(d_rd_err_i), .d_rd_data_i(d_rd_data_i),
    .d_wr_ack_i(d_wr_ack_i),
`ifdef CSR_CPUIF_TIMEOUT_STATUS_EN
    .timeout_count_o(timeout_count_o), .timeout_addr_o(timeout_addr_o),
    .timeout_status_clr_i(timeout_status_clr_i),
`endif
    .d_wr_err_i(d_wr_err_i)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input logic is_wr, input logic err, input logic [DW-1:0] data);
    exp_t e;
    e.is_wr = is_wr;
    e.err   = err;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every upstream ack pops one expected response.
  task automatic monitor();
    exp_t e;
    if (rst_ni) begin
      if (u_rd_ack_o || u_wr_ack_o) begin
        if (exp_q.size() == 0) begin
          check_value("unexpected_ack", {62'd0, u_wr_ack_o, u_rd_ack_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_value("ack_rd", u_rd_ack_o, !e.is_wr);
          check_value("ack_wr", u_wr_ack_o, e.is_wr);
          check_value("ack_err", e.is_wr ? u_wr_err_o : u_rd_err_o, e.err);
          check_value("ack_data", u_rd_data_o, e.is_wr ? '0 : e.data);
        end
      end else begin
        check_value("rd_data_idle", u_rd_data_o, 64'd0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    monitor();
  endtask

  task automatic drive_req(input logic is_wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] biten);
    u_req_i       = 1'b1;
    u_req_is_wr_i = is_wr;
    u_addr_i      = addr;
    u_wr_data_i   = wdata;
    u_wr_biten_i  = biten;
  endtask

  task automatic drop_req();
    u_req_i      = 1'b0;
    u_addr_i     = '0;
    u_wr_data_i  = '0;
    u_wr_biten_i = '0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_value("rst_d_req", d_req_o, 1'b0);
    check_value("rst_stall", {u_req_stall_wr_o, u_req_stall_rd_o}, 2'b00);
    check_value("rst_acks", {u_rd_ack_o, u_wr_ack_o}, 2'b00);
    check_value("rst_addr", d_addr_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    // Read with an ack in the issue cycle
    drive_req(1'b0, 32'h10, 32'h0, 32'h0);
    expect_resp(1'b0, 1'b0, 32'h1234_5678);
    check_value("t1_idle_stall", u_req_stall_rd_o, 1'b0);
    tick();
    drop_req();
    check_value("t1_d_req", d_req_o, 1'b1);
    check_value("t1_d_addr", d_addr_o, 32'h10);
    check_value("t1_d_is_wr", d_req_is_wr_o, 1'b0);
    check_value("t1_stall", u_req_stall_rd_o, 1'b1);
    d_rd_ack_i  = 1'b1;
    d_rd_data_i = 32'h1234_5678;
    tick();
    d_rd_ack_i  = 1'b0;
    d_rd_data_i = '0;
    check_value("t1_ack_lat", u_rd_ack_o, 1'b1);
    check_value("t1_d_req_drop", d_req_o, 1'b0);
    tick();
    check_value("t1_idle", u_req_stall_rd_o, 1'b0);

    // Write held by a 4-cycle downstream stall
    drive_req(1'b1, 32'h20, 32'hA5A5_A5A5, 32'h0000_FFFF);
    expect_resp(1'b1, 1'b0, 32'h0);
    tick();
    drop_req();
    d_req_stall_wr_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        d_req_stall_wr_i = 1'b0;
        d_wr_ack_i       = 1'b1;
      end
      check_value("t2_d_req", d_req_o, 1'b1);
      check_value("t2_fields", {d_req_is_wr_o, d_addr_o, d_wr_data_o, d_wr_biten_o},
                  {1'b1, 32'h20, 32'hA5A5_A5A5, 32'h0000_FFFF});
      check_value("t2_stall", u_req_stall_wr_o, 1'b1);
      tick();
    end
    d_wr_ack_i = 1'b0;
    check_value("t2_ack", u_wr_ack_o, 1'b1);
    check_value("t2_d_req_drop", d_req_o, 1'b0);
    tick();
    check_value("t2_single_ack", u_wr_ack_o, 1'b0);

    // Read that never gets acked times out, late ack is dropped
    drive_req(1'b0, 32'h30, 32'h0, 32'h0);
    expect_resp(1'b0, 1'b1, 32'hDEAD_C0DE);
    tick();
    drop_req();
    repeat (7) tick();
    check_value("t3_pre_expiry", u_rd_ack_o, 1'b0);
    tick();
    check_value("t3_timeout_ack", u_rd_ack_o, 1'b1);
    repeat (3) tick();
    d_rd_ack_i  = 1'b1;
    d_rd_data_i = 32'h1111_1111;
    tick();
    d_rd_ack_i  = 1'b0;
    d_rd_data_i = '0;
    tick();
    tick();
    check_value("t3_late_idle", {u_req_stall_rd_o, d_req_o}, 2'b00);
`ifdef CSR_CPUIF_TIMEOUT_STATUS_EN
    check_value("t3_tmo_count", timeout_count_o, 8'd1);
    check_value("t3_tmo_addr", timeout_addr_o, 32'h30);
`endif

    // Ack coincides with the last budget cycle: normal response wins
    drive_req(1'b0, 32'h40, 32'h0, 32'h0);
    expect_resp(1'b0, 1'b0, 32'hCAFE_0001);
    tick();
    drop_req();
    repeat (6) tick();
    check_value("t4_no_ack_yet", u_rd_ack_o, 1'b0);
    tick();
    d_rd_ack_i  = 1'b1;
    d_rd_data_i = 32'hCAFE_0001;
    tick();
    d_rd_ack_i  = 1'b0;
    d_rd_data_i = '0;
    check_value("t4_ack", u_rd_ack_o, 1'b1);
    tick();
`ifdef CSR_CPUIF_TIMEOUT_STATUS_EN
    check_value("t4_tmo_count", timeout_count_o, 8'd1);
`endif

    // Second request and stray write ack while a read is outstanding
    drive_req(1'b0, 32'h50, 32'h0, 32'h0);
    expect_resp(1'b0, 1'b1, 32'h0BAD_F00D);
    tick();
    drive_req(1'b1, 32'h60, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    d_wr_ack_i = 1'b1;
    d_wr_err_i = 1'b1;
    check_value("t5_wait_noreq", d_req_o, 1'b0);
    check_value("t5_stall_wr", u_req_stall_wr_o, 1'b1);
    tick();
    drop_req();
    d_wr_ack_i = 1'b0;
    d_wr_err_i = 1'b0;
    check_value("t5_stray_ignored", {u_wr_ack_o, u_rd_ack_o, u_req_stall_rd_o}, 3'b001);
    tick();
    d_rd_ack_i  = 1'b1;
    d_rd_err_i  = 1'b1;
    d_rd_data_i = 32'h0BAD_F00D;
    tick();
    d_rd_ack_i  = 1'b0;
    d_rd_err_i  = 1'b0;
    d_rd_data_i = '0;
    check_value("t5_ack", u_rd_ack_o, 1'b1);
    tick();
    tick();
    check_value("t5_no_second", {d_req_o, u_req_stall_rd_o}, 2'b00);
    check_value("t5_addr_kept", d_addr_o, 32'h50);

    // Reset during WAIT aborts silently, next access works
    drive_req(1'b0, 32'h70, 32'h0, 32'h0);
    tick();
    drop_req();
    tick();
    rst_ni = 1'b0;
    #1;
    check_value("t6_rst_outs", {d_req_o, u_req_stall_wr_o, u_req_stall_rd_o, u_rd_ack_o, u_wr_ack_o},
                5'b00000);
    check_value("t6_rst_addr", d_addr_o, 32'h0);
`ifdef CSR_CPUIF_TIMEOUT_STATUS_EN
    check_value("t6_rst_tmo", {timeout_count_o, timeout_addr_o}, 40'h0);
`endif
    tick();
    rst_ni = 1'b1;
    tick();
    check_value("t6_post_rst_idle", u_req_stall_rd_o, 1'b0);
    drive_req(1'b0, 32'h74, 32'h0, 32'h0);
    expect_resp(1'b0, 1'b0, 32'h55AA_55AA);
    tick();
    drop_req();
    check_value("t6_d_addr", d_addr_o, 32'h74);
    d_rd_ack_i  = 1'b1;
    d_rd_data_i = 32'h55AA_55AA;
    tick();
    d_rd_ack_i  = 1'b0;
    d_rd_data_i = '0;
    check_value("t6_ack", u_rd_ack_o, 1'b1);
    tick();
    tick();

    check_value("queue_empty", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
